// File: rtl/fsm_step_sequencer.sv
// Step sequencer for a generated FSM: applies stored condition vectors one per step,
// pulses the FSM enable, and records the post-advance state/outputs into a trace buffer.
module fsm_step_sequencer #(
    parameter int unsigned COND_W  = 2,
    parameter int unsigned STATE_W = 2,
    parameter int unsigned OUT_W   = 2,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ADDR_W  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_run,
    input  logic                       cmd_step,
    input  logic                       cmd_stop,
    input  logic [ADDR_W:0]            num_steps,
    input  logic                       load_we,
    input  logic [ADDR_W-1:0]          load_addr,
    input  logic [COND_W-1:0]          load_data,
    output logic [COND_W-1:0]          cond_sig,
    output logic                       fsm_en,
    input  logic [STATE_W-1:0]         fsm_state,
    input  logic [OUT_W-1:0]           fsm_out,
    input  logic [ADDR_W-1:0]          trace_addr,
    output logic [STATE_W+OUT_W-1:0]   trace_data,
    output logic [ADDR_W:0]            step_idx,
    output logic                       busy,
    output logic                       paused,
    output logic                       done
);

    localparam int unsigned CNT_W   = ADDR_W + 1;
    localparam int unsigned TRACE_W = STATE_W + OUT_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_STEP,
        S_CAPTURE,
        S_PAUSE,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic                 mode_step_q, mode_step_d;
    logic [CNT_W-1:0]     limit_q, limit_d;
    logic [CNT_W-1:0]     step_idx_q, step_idx_d;
    logic [COND_W-1:0]    cond_sig_q, cond_sig_d;
    logic                 fsm_en_q, fsm_en_d;
    logic                 busy_q, busy_d;
    logic                 paused_q, paused_d;
    logic                 done_q, done_d;
    logic [TRACE_W-1:0]   trace_data_q, trace_data_d;

    logic [COND_W-1:0]    stim_mem  [DEPTH];
    logic [TRACE_W-1:0]   trace_mem [DEPTH];

    logic                 stim_we_c;
    logic                 trace_we_c;
    logic [ADDR_W-1:0]    idx_c;
    logic [CNT_W-1:0]     idx_inc_c;
    logic [CNT_W-1:0]     limit_c;
    logic                 start_c;

    assign idx_c     = step_idx_q[ADDR_W-1:0];
    assign idx_inc_c = step_idx_q + CNT_W'(1);
    assign limit_c   = (num_steps > DEPTH_C) ? DEPTH_C : num_steps;
    assign start_c   = cmd_step | cmd_run;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d      = state_q;
        mode_step_d  = mode_step_q;
        limit_d      = limit_q;
        step_idx_d   = step_idx_q;
        cond_sig_d   = cond_sig_q;
        trace_we_c   = 1'b0;
        trace_data_d = trace_mem[trace_addr];

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (cmd_stop) begin
                    state_d    = S_IDLE;
                    if (state_q == S_DONE) begin
                        cond_sig_d = '0;
                    end
                end else if (start_c) begin
                    step_idx_d  = '0;
                    limit_d     = limit_c;
                    mode_step_d = cmd_step;
                    state_d     = (limit_c == '0) ? S_DONE : S_APPLY;
                end
            end
            S_APPLY: begin
                if (cmd_stop) begin
                    state_d    = S_IDLE;
                    cond_sig_d = '0;
                end else begin
                    cond_sig_d = stim_mem[idx_c];
                    state_d    = S_STEP;
                end
            end
            S_STEP: begin
                if (cmd_stop) begin
                    state_d    = S_IDLE;
                    cond_sig_d = '0;
                end else begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (cmd_stop) begin
                    state_d    = S_IDLE;
                    cond_sig_d = '0;
                end else begin
                    trace_we_c = 1'b1;
                    step_idx_d = idx_inc_c;
                    if (idx_inc_c == limit_q) begin
                        state_d = S_DONE;
                    end else if (mode_step_q) begin
                        state_d = S_PAUSE;
                    end else begin
                        state_d = S_APPLY;
                    end
                end
            end
            S_PAUSE: begin
                if (cmd_stop) begin
                    state_d    = S_IDLE;
                    cond_sig_d = '0;
                end else if (cmd_step) begin
                    mode_step_d = 1'b1;
                    state_d     = S_APPLY;
                end else if (cmd_run) begin
                    mode_step_d = 1'b0;
                    state_d     = S_APPLY;
                end
            end
            default: begin
                state_d    = S_IDLE;
                cond_sig_d = '0;
            end
        endcase

        // Status flags follow the state being entered so they are valid with it.
        fsm_en_d = (state_d == S_STEP);
        busy_d   = (state_d == S_APPLY) || (state_d == S_STEP) || (state_d == S_CAPTURE);
        paused_d = (state_d == S_PAUSE);
        done_d   = (state_d == S_DONE);
    end

    assign stim_we_c = load_we &&
                       ((state_q == S_IDLE) || (state_q == S_PAUSE) || (state_q == S_DONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mode_step_q  <= 1'b0;
            limit_q      <= '0;
            step_idx_q   <= '0;
            cond_sig_q   <= '0;
            fsm_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            paused_q     <= 1'b0;
            done_q       <= 1'b0;
            trace_data_q <= '0;
        end else begin
            state_q      <= state_d;
            mode_step_q  <= mode_step_d;
            limit_q      <= limit_d;
            step_idx_q   <= step_idx_d;
            cond_sig_q   <= cond_sig_d;
            fsm_en_q     <= fsm_en_d;
            busy_q       <= busy_d;
            paused_q     <= paused_d;
            done_q       <= done_d;
            trace_data_q <= trace_data_d;
        end
    end

    // Storage arrays carry no reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (stim_we_c) begin
            stim_mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (trace_we_c) begin
            trace_mem[idx_c] <= {fsm_state, fsm_out};
        end
    end

    assign cond_sig   = cond_sig_q;
    assign fsm_en     = fsm_en_q;
    assign trace_data = trace_data_q;
    assign step_idx   = step_idx_q;
    assign busy       = busy_q;
    assign paused     = paused_q;
    assign done       = done_q;

    a_en_single: assert property (@(posedge clk) disable iff (rst) fsm_en_q |=> !fsm_en_q);

endmodule

// File: doc/fsm_step_sequencer.md
Name: fsm_step_sequencer

Overview:
- Controller that drives a generated FSM from the circuit-to-Verilog flow.
- Applies a programmed sequence of condition vectors to the FSM's cond_sig input, one vector per step.
- Gates FSM state advance with a single-cycle enable per step.
- Captures the resulting state and outputs into a trace buffer, which the app reads back for waveform and state-diagram playback.

Parameters:
- COND_W, 2, width of the FSM condition vector (cond_sig)
- STATE_W, 2, width of the FSM state register
- OUT_W, 2, width of the FSM output vector (outSignals)
- DEPTH, 16, number of stimulus/trace entries
- ADDR_W, 4, log2(DEPTH)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_run  in  1  pulse: run all remaining steps
- cmd_step  in  1  pulse: execute exactly one step
- cmd_stop  in  1  pulse: abort and return to IDLE
- num_steps  in  ADDR_W+1  steps per sequence; sampled on start from IDLE/DONE
- load_we  in  1  stimulus memory write enable
- load_addr  in  ADDR_W  stimulus write address
- load_data  in  COND_W  stimulus write data
- cond_sig  out  COND_W  condition vector to FSM (registered)
- fsm_en  out  1  FSM state-advance enable, one cycle per step
- fsm_state  in  STATE_W  current FSM state
- fsm_out  in  OUT_W  current FSM outputs (Moore)
- trace_addr  in  ADDR_W  trace read address
- trace_data  out  STATE_W+OUT_W  {state, out} at trace_addr; 1-cycle registered read
- step_idx  out  ADDR_W+1  steps completed in current sequence
- busy  out  1  high in APPLY/STEP/CAPTURE
- paused  out  1  high in PAUSE
- done  out  1  high in DONE

Behaviour:
- Reset: state=IDLE; cond_sig=0, fsm_en=0, step_idx=0, busy=0, paused=0, done=0, trace_data=0. Memory contents are not reset.
- Command priority: cmd_stop > cmd_step > cmd_run when asserted in the same cycle.
- Effective step limit is N = min(num_steps, DEPTH), latched when a sequence starts.
- IDLE or DONE, on run or step:
  - step_idx is cleared to 0 and N is latched.
  - If N==0: go to DONE with no fsm_en pulse.
  - Otherwise go to APPLY; mode = run or step.
- APPLY (1 cycle): cond_sig <= stim[step_idx]. Next state is STEP.
- STEP (1 cycle): fsm_en=1; cond_sig held. Next state is CAPTURE.
- CAPTURE (1 cycle):
  - trace[step_idx] <= {fsm_state, fsm_out}, i.e. the post-advance values.
  - step_idx++.
  - If step_idx+1==N: go to DONE. Else if mode==step: go to PAUSE. Else go to APPLY.
- Cost is 3 cycles per step. fsm_en is never high for two consecutive cycles.
- PAUSE: outputs held, cond_sig held.
  - cmd_step goes to APPLY with mode=step; cmd_run goes to APPLY with mode=run.
  - step_idx and N are not reloaded.
- DONE: done held high, cond_sig held. A new run or step restarts from index 0 and overwrites the trace.
- cmd_stop in any non-IDLE state:
  - Go to IDLE, force fsm_en=0 and cond_sig=0.
  - Clear step_idx only on the next start.
  - A stop in STEP still produces that cycle's fsm_en (registered), but no trace write occurs.
- Commands other than stop are ignored in APPLY, STEP and CAPTURE.
- load_we is honoured only in IDLE, PAUSE and DONE; it is ignored while busy.
- Trace reads are allowed in any state. Reading an entry in the same cycle it is written returns the old value.
- Asserting rst mid-sequence returns to IDLE asynchronously, with all outputs at their reset values.

Test Plan:
- Using the reference 2-bit FSM (00 -cond 00-> 10, 00 -cond 11-> 01, 01->00, 10->01), load stim {00,00,00,11} with num_steps=4, then cmd_run → exactly 4 fsm_en pulses spaced 3 cycles apart; trace states 10,01,00,01; done after 12 cycles; step_idx=4.
- Same program driven by cmd_step ×4 → paused=1 between steps; trace identical; step_idx increments 1→4; done after the 4th step.
- num_steps=0 with cmd_run → DONE on the next cycle, no fsm_en pulse, trace unchanged.
- num_steps=20 with DEPTH=16 → 16 steps executed; step_idx=16; no write past index 15.
- cmd_stop asserted during step 2 of a run → IDLE, cond_sig=0, busy=0; a following cmd_run restarts at index 0.
- cmd_run and cmd_stop in the same cycle from IDLE → stays in IDLE. rst asserted in CAPTURE → all outputs 0 immediately; load_we while busy → stimulus memory unchanged.
